// File: rtl/bin2bcd_blank.sv
// bin2bcd_blank: sequential binary-to-BCD converter (double dabble, one bit
// per clock) with leading-zero blanking for a seven-segment display chain.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; digits/ovf hold the last result
// SHIFT   | BIN_W cycles of add-3 then shift {bcd, bin_sr} left
// FIN     | one cycle: blank leading zeros or flag overflow, pulse done
module bin2bcd_blank #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAXV = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   sr_q;
  logic [BIN_W-1:0]   sr_d;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [BCD_W-1:0]   digits_q;
  logic [BCD_W-1:0]   digits_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic               ovf_in;
  logic               busy_q;
  logic               done_q;
  logic               ovf_q;

  // Range check of the incoming value, done at capture time
  assign ovf_in = (64'(bin) > MAXV);

  // Add-3 correction on every nibble >= 5, then shift the combined register
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1]};
    sr_d  = {sr_q[BIN_W-2:0], 1'b0};
  end

  // Leading-zero blanking; the ones digit is always shown so 0 reads "0"
  always_comb begin
    logic lead;
    lead     = 1'b1;
    digits_d = bcd_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) digits_d[4*i +: 4] = 4'hF;
      else                                    lead = 1'b0;
    end
  end

  // Conversion sequencer with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q       <= bin;
            bcd_q      <= '0;
            ovf_pend_q <= ovf_in;
            cnt_q      <= CNT_W'(BIN_W);
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_FIN;
        end
        ST_FIN: begin
          if (ovf_pend_q) begin
            digits_q <= '1;
            ovf_q    <= 1'b1;
          end else begin
            digits_q <= digits_d;
            ovf_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;

endmodule

// File: tb/tb_bin2bcd_blank.sv
// Self-checking bench for bin2bcd_blank: directed corner cases plus random
// values, compared against a decimal-arithmetic reference model.
module tb_bin2bcd_blank;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] digits;

  int errors = 0;
  int checks = 0;

  logic [15:0] cur_dig;
  logic        cur_ovf;

  bin2bcd_blank #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .digits  (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v; positions above the value's length are blank
  function automatic logic [15:0] ref_digits(input int v);
    logic [15:0] r;
    int len;
    int p;
    if (v > 9999) return 16'hFFFF;
    len = 1;
    while (len < 4 && v >= pow10i(len)) len++;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < len) r[4*i +: 4] = 4'((v / p) % 10);
      else         r[4*i +: 4] = 4'hF;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int pow10i(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Drive start with value v now (caller is away from the edge); consumes edge 0
  task automatic launch(input int v);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  // Walk edges 1..15 checking busy/hold behaviour, then the result at edge 15.
  // poke > 0 asserts start (bin = 77) for one cycle after that edge.
  task automatic wait_result(input int v, input int poke);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k < 15) begin
        chk("busy_run", busy, 1);
        chk("done_early", done, 0);
        chk("digits_hold", digits, cur_dig);
        chk("ovf_hold", ovf, cur_ovf);
      end else begin
        cur_dig = ref_digits(v);
        cur_ovf = (v > 9999);
        chk("done_pulse", done, 1);
        chk("busy_fin", busy, 0);
        chk("digits", digits, cur_dig);
        chk("ovf", ovf, cur_ovf);
      end
      if (k == poke) begin
        start = 1'b1;
        bin   = 14'd77;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_digits", digits, cur_dig);
    end
  endtask

  initial begin
    int dir_vals[$] = '{0, 1234, 705, 9999, 10000, 42, 1, 9, 10, 99, 100, 999,
                        1000, 16383, 5, 50, 9990};
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    cur_dig = 16'hFFFF;
    cur_ovf = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits, 16'hFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(2);

    // Directed values, with an idle gap between conversions
    foreach (dir_vals[i]) begin
      @(negedge clk);
      launch(dir_vals[i]);
      wait_result(dir_vals[i], 0);
      idle_check(1);
    end

    // Start while busy is ignored
    @(negedge clk);
    launch(8);
    wait_result(8, 5);
    chk("busy_ign_digits", digits, 16'hFFF8);
    idle_check(20);

    // Back-to-back: second start during the done cycle
    @(negedge clk);
    launch(500);
    wait_result(500, 0);
    chk("b2b_first", digits, 16'hF500);
    launch(31);
    wait_result(31, 0);
    chk("b2b_second", digits, 16'hFF31);
    idle_check(1);

    // Reset mid-conversion: outputs return to reset values, no done follows
    @(negedge clk);
    launch(1234);
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_digits", digits, 16'hFFFF);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    cur_dig = 16'hFFFF;
    cur_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(20);

    // Random values, mostly in range, some over range
    for (int n = 0; n < 1500; n++) begin
      int v;
      if ($urandom_range(0, 7) == 0) v = $urandom_range(10000, 16383);
      else                           v = $urandom_range(0, 9999);
      @(negedge clk);
      launch(v);
      wait_result(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0);
    end
    idle_check(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
